// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline hazard/redirect controller:
// pipe-register stage indices, controller FSM states and mask helpers.
package pipe_ctrl_pkg;

  localparam int STG_IF_ID  = 0;
  localparam int STG_ID_EX  = 1;
  localparam int STG_EX_MEM = 2;
  localparam int STG_MEM_WB = 3;
  localparam int NUM_STG    = 4;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    EXC_HOLD  = 2'd1,
    EXC_FLUSH = 2'd2
  } pipe_state_e;

  // One-hot mask selecting a single pipe register.
  function automatic logic [NUM_STG-1:0] stg_bit(input int unsigned idx);
    stg_bit = 4'b0001 << idx;
  endfunction

  // Mask selecting pipe registers 0 .. idx inclusive (everything upstream of a hazard).
  function automatic logic [NUM_STG-1:0] stg_upto(input int unsigned idx);
    stg_upto = (4'b0001 << (idx + 32'd1)) - 4'b0001;
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Hazard request / pipeline control bundle between the pipeline stages
// (master: raises requests, obeys stall/flush/redirect) and pipe_ctrl (slave).
interface pipe_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              id_stall_req;
  logic              ex_stall_req;
  logic              mem_stall_req;
  logic              br_req;
  logic [ADDR_W-1:0] br_target;
  logic              except_req;
  logic [ADDR_W-1:0] except_target;
  logic [3:0]        stall;
  logic [3:0]        flush;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;

  modport master (
    output id_stall_req, ex_stall_req, mem_stall_req,
    output br_req, br_target, except_req, except_target,
    input  stall, flush, redirect_valid, redirect_pc
  );

  modport slave (
    input  id_stall_req, ex_stall_req, mem_stall_req,
    input  br_req, br_target, except_req, except_target,
    output stall, flush, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/pipe_perf_cnt.sv
// Free-running performance counters for the pipeline controller:
// cycles spent with any pipe register held, and cycles with a fetch redirect.
// Both wrap at 2^32. Only instantiated when PIPE_CTRL_PERF_EN is defined.
module pipe_perf_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_any,
  input  logic        redirect,
  output logic [31:0] perf_stall_cyc,
  output logic [31:0] perf_flush_cnt
);

  logic [31:0] stall_cyc_r;
  logic [31:0] flush_cnt_r;

  // Count stall cycles and redirect cycles, wrapping naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cyc_r <= 32'd0;
      flush_cnt_r <= 32'd0;
    end else begin
      stall_cyc_r <= stall_any ? stall_cyc_r + 32'd1 : stall_cyc_r;
      flush_cnt_r <= redirect  ? flush_cnt_r + 32'd1 : flush_cnt_r;
    end
  end

  assign perf_stall_cyc = stall_cyc_r;
  assign perf_flush_cnt = flush_cnt_r;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard / redirect controller.
// In RUN, hazards resolve combinationally (mem > ex > branch > id) so stalls
// and branch redirects act in the same cycle. An accepted exception walks
// EXC_HOLD (freeze everything) then EXC_FLUSH (bubble everything + redirect).
// Optional feature macro: PIPE_CTRL_PERF_EN adds perf counter outputs.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic        clk,
  input  logic        rst,
  pipe_ctrl_if.slave  bus
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0] perf_stall_cyc,
  output logic [31:0] perf_flush_cnt
`endif
);

  pipe_state_e       state_r;
  pipe_state_e       state_nxt_s;
  logic [ADDR_W-1:0] exc_pc_r;
  logic              exc_accept_s;
  logic [3:0]        stall_s;
  logic [3:0]        flush_s;
  logic              redir_valid_s;
  logic [ADDR_W-1:0] redir_pc_s;

  // Next-state and control outputs; reset forces everything quiet.
  always_comb begin
    state_nxt_s   = state_r;
    exc_accept_s  = 1'b0;
    stall_s       = 4'b0000;
    flush_s       = 4'b0000;
    redir_valid_s = 1'b0;
    redir_pc_s    = {ADDR_W{1'b0}};
    if (rst) begin
      state_nxt_s = RUN;
    end else begin
      case (state_r)
        RUN: begin
          // An exception cannot enter while the LSU still owns MEM.
          exc_accept_s = bus.except_req && !bus.mem_stall_req;
          if (exc_accept_s) begin
            state_nxt_s = EXC_HOLD;
          end else begin
            state_nxt_s = RUN;
          end
          if (bus.mem_stall_req) begin
            stall_s = stg_upto(STG_EX_MEM);
            flush_s = stg_bit(STG_MEM_WB);
          end else if (bus.ex_stall_req) begin
            stall_s = stg_upto(STG_ID_EX);
            flush_s = stg_bit(STG_EX_MEM);
          end else if (bus.br_req && !exc_accept_s) begin
            // The exception owns the redirect path, so a concurrent branch is dropped.
            flush_s       = stg_upto(STG_ID_EX);
            redir_valid_s = 1'b1;
            redir_pc_s    = bus.br_target;
          end else if (bus.id_stall_req) begin
            stall_s = stg_upto(STG_IF_ID);
            flush_s = stg_bit(STG_ID_EX);
          end else begin
            stall_s = 4'b0000;
            flush_s = 4'b0000;
          end
        end
        EXC_HOLD: begin
          stall_s     = stg_upto(STG_MEM_WB);
          state_nxt_s = EXC_FLUSH;
        end
        EXC_FLUSH: begin
          flush_s       = stg_upto(STG_MEM_WB);
          redir_valid_s = 1'b1;
          redir_pc_s    = exc_pc_r;
          state_nxt_s   = RUN;
        end
        default: begin
          state_nxt_s = RUN;
        end
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= RUN;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Capture the handler entry when the exception is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      exc_pc_r <= {ADDR_W{1'b0}};
    end else if (exc_accept_s) begin
      exc_pc_r <= bus.except_target;
    end else begin
      exc_pc_r <= exc_pc_r;
    end
  end

  assign bus.stall          = stall_s;
  assign bus.flush          = flush_s;
  assign bus.redirect_valid = redir_valid_s;
  assign bus.redirect_pc    = redir_pc_s;

`ifdef PIPE_CTRL_PERF_EN
  pipe_perf_cnt u_perf (
    .clk            (clk),
    .rst            (rst),
    .stall_any      (|stall_s),
    .redirect       (redir_valid_s),
    .perf_stall_cyc (perf_stall_cyc),
    .perf_flush_cnt (perf_flush_cnt)
  );
`endif

endmodule
